fact_dispatch: RTL and testbench

//  Memory-mapped job scheduler for the four factorial units. CPU writes factorial

---
 rtl/fact_dispatch_if.sv | 25 ++
 rtl/fact_dispatch.sv | 133 +++++++++++++
 tb/tb_fact_dispatch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fact_dispatch_if.sv
// CPU register bus and factorial-unit handshake bundle for fact_dispatch.
// master = CPU/unit side driving requests, slave = the dispatcher.
interface fact_dispatch_if #(
    parameter int NUM_UNITS = 4,
    parameter int N_W       = 4
);
    logic [31:0]          input_addr;
    logic                 write_enable;
    logic [31:0]          write_data;
    logic [31:0]          read_data;
    logic [NUM_UNITS-1:0] unit_done;
    logic [NUM_UNITS-1:0] unit_go;
    logic [N_W-1:0]       unit_n;
    logic [NUM_UNITS-1:0] done_irq;

    modport master (
        output input_addr, write_enable, write_data, unit_done,
        input  read_data, unit_go, unit_n, done_irq
    );

    modport slave (
        input  input_addr, write_enable, write_data, unit_done,
        output read_data, unit_go, unit_n, done_irq
    );
endinterface

// File: rtl/fact_dispatch.sv
// Factorial job scheduler: CPU-fed submit FIFO, round-robin one-cycle go pulse per job.
// Write-to-go latency 2 cycles when idle; full FIFO drops the job and sets sticky ovf.
module fact_dispatch #(
    parameter int          NUM_UNITS = 4,
    parameter int          N_W       = 4,
    parameter int          QDEPTH    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7000
) (
    input logic            clk,
    input logic            rst,
    fact_dispatch_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int UW = $clog2(NUM_UNITS);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state;
    logic [N_W-1:0]       fifo_mem [QDEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [NUM_UNITS-1:0] busy;
    logic [UW-1:0]        rr_ptr;
    logic                 ovf;
    logic [N_W-1:0]       job_n [NUM_UNITS];

    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 wr_submit;
    logic                 wr_status;
    logic                 push;
    logic                 pop;
    logic                 any_free;
    logic [UW-1:0]        cand;
    logic [UW-1:0]        sel_idx;
    logic                 sel_found;
    logic [NUM_UNITS-1:0] sel_mask;
    logic [31:0]          status_word;
    logic [31:0]          rd_word;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(QDEPTH));
    assign wr_submit  = bus.write_enable && (bus.input_addr == BASE_ADDR);
    assign wr_status  = bus.write_enable && (bus.input_addr == BASE_ADDR + 32'h4);
    // Fullness is judged on the registered count, so a same-cycle pop cannot rescue a push.
    assign push       = wr_submit && !fifo_full;
    assign any_free   = ~&busy;
    assign pop        = (state == ISSUE) && sel_found && !fifo_empty;

    // Busy is registered, so a unit finishing this cycle is only eligible next cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        sel_mask  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cand = rr_ptr + UW'(i);
            if (!sel_found && !busy[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
        sel_mask[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.write_data[N_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            busy         <= '0;
            rr_ptr       <= '0;
            ovf          <= 1'b0;
            bus.unit_go  <= '0;
            bus.unit_n   <= '0;
            bus.done_irq <= '0;
            for (int k = 0; k < NUM_UNITS; k++) job_n[k] <= '0;
        end else begin
            bus.unit_go  <= '0;
            bus.done_irq <= bus.unit_done;
            busy         <= (busy & ~bus.unit_done) | (pop ? sel_mask : '0);

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (wr_submit && fifo_full)              ovf <= 1'b1;
            else if (wr_status && bus.write_data[16]) ovf <= 1'b0;

            case (state)
                IDLE: if (!fifo_empty && any_free) state <= ISSUE;
                ISSUE: begin
                    if (pop) begin
                        bus.unit_go    <= sel_mask;
                        bus.unit_n     <= fifo_mem[rd_ptr];
                        job_n[sel_idx] <= fifo_mem[rd_ptr];
                        rr_ptr         <= sel_idx + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        status_word                   = '0;
        status_word[CW-1:0]           = count;
        status_word[4 +: NUM_UNITS]   = busy;
        status_word[8]                = fifo_full;
        status_word[9]                = fifo_empty;
        status_word[16]               = ovf;

        rd_word = '0;
        if (bus.input_addr == BASE_ADDR + 32'h4) rd_word = status_word;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (bus.input_addr == BASE_ADDR + 32'h10 + 32'(k) * 32'd4)
                rd_word = {busy[k], {(31 - N_W){1'b0}}, job_n[k]};
        end
        bus.read_data = rd_word;
    end
endmodule

// File: tb/tb_fact_dispatch.sv
// Bench for fact_dispatch: dispatch scoreboard plus register/timing checks.
`timescale 1ns/100ps
module tb_fact_dispatch;
    localparam logic [31:0] SUBMIT = 32'h0000_7000;
    localparam logic [31:0] STATUS = 32'h0000_7004;
    localparam logic [31:0] JOB0   = 32'h0000_7010;

    typedef struct packed {
        logic [3:0] go;
        logic [3:0] n;
    } exp_t;

    typedef struct {
        logic [3:0] n;
        logic [3:0] go;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;
    int go_seen = 0;
    int exp_total = 0;
    exp_t sb[$];
    exp_t mon_exp;
    vec_t vecs[5];
    logic [31:0] rd;

    fact_dispatch_if #(.NUM_UNITS(4), .N_W(4)) bus ();

    fact_dispatch #(
        .NUM_UNITS(4), .N_W(4), .QDEPTH(4), .BASE_ADDR(32'h0000_7000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
        bus.input_addr   = addr;
        bus.write_data   = data;
        bus.write_enable = 1'b1;
        step();
        bus.write_enable = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
        bus.input_addr = addr;
        #1;
        data = bus.read_data;
    endtask

    task automatic expect_go(input logic [3:0] go, input logic [3:0] n);
        exp_t e;
        e.go = go;
        e.n  = n;
        sb.push_back(e);
        exp_total++;
    endtask

    task automatic wait_go(input string name);
        int k = 0;
        while (go_seen < exp_total && k < 40) begin
            step();
            k++;
        end
        check(name, go_seen, exp_total);
    endtask

    // Every go pulse must match the next expected dispatch, in order.
    always @(negedge clk) begin
        if (bus.unit_go !== 4'b0000) begin
            go_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_go: got go=%b n=%0d, required no dispatch",
                         bus.unit_go, bus.unit_n);
            end else begin
                mon_exp = sb.pop_front();
                check("sb_go", {28'd0, bus.unit_go}, {28'd0, mon_exp.go});
                check("sb_n",  {28'd0, bus.unit_n},  {28'd0, mon_exp.n});
            end
        end
    end

    initial begin
        vecs[0] = '{n: 4'd5, go: 4'b0001};
        vecs[1] = '{n: 4'd6, go: 4'b0010};
        vecs[2] = '{n: 4'd7, go: 4'b0100};
        vecs[3] = '{n: 4'd8, go: 4'b1000};
        vecs[4] = '{n: 4'd9, go: 4'b0000};

        bus.input_addr   = '0;
        bus.write_data   = '0;
        bus.write_enable = 1'b0;
        bus.unit_done    = '0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();

        // Reset state
        cpu_read(STATUS, rd); check("rst_status", rd, 32'h0000_0200);
        cpu_read(JOB0, rd);   check("rst_job0", rd, 32'h0);
        check("rst_go", {28'd0, bus.unit_go}, 32'h0);
        check("rst_n", {28'd0, bus.unit_n}, 32'h0);
        check("rst_irq", {28'd0, bus.done_irq}, 32'h0);

        // Single job: go visible exactly two cycles after the write edge
        expect_go(4'b0001, 4'd5);
        cpu_write(SUBMIT, 32'd5);
        check("t1_go_e0", {28'd0, bus.unit_go}, 32'h0);
        step();
        check("t1_go_e1", {28'd0, bus.unit_go}, 32'h0);
        step();
        check("t1_go_e2", {28'd0, bus.unit_go}, 32'h1);
        check("t1_n_e2", {28'd0, bus.unit_n}, 32'h5);
        cpu_read(STATUS, rd); check("t1_status", rd, 32'h0000_0210);
        cpu_read(JOB0, rd);   check("t1_job0", rd, 32'h8000_0005);
        bus.unit_done = 4'b0001;
        step();
        bus.unit_done = 4'b0000;
        check("t1_irq", {28'd0, bus.done_irq}, 32'h1);
        cpu_read(STATUS, rd); check("t1_status_free", rd, 32'h0000_0200);
        wait_go("t1_drain");

        // Back-to-back submits from a fresh round-robin pointer
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].go != 4'b0000) expect_go(vecs[i].go, vecs[i].n);
            cpu_write(SUBMIT, {28'd0, vecs[i].n});
        end
        wait_go("t2_gos");
        step();
        step();
        cpu_read(STATUS, rd); check("t2_status", rd, 32'h0000_00F1);
        cpu_read(JOB0 + 32'hC, rd); check("t2_job3", rd, 32'h8000_0008);

        // Fill to full, overflow, then clear the sticky flag
        cpu_write(SUBMIT, 32'd10);
        cpu_write(SUBMIT, 32'd11);
        cpu_write(SUBMIT, 32'd12);
        cpu_read(STATUS, rd); check("t3_full", rd, 32'h0000_01F4);
        cpu_write(SUBMIT, 32'd13);
        cpu_read(STATUS, rd); check("t3_ovf", rd, 32'h0001_01F4);
        cpu_write(STATUS, 32'h0001_0000);
        cpu_read(STATUS, rd); check("t3_ovf_clr", rd, 32'h0000_01F4);

        // One unit finishes: irq one cycle later, queued job goes to it
        expect_go(4'b0100, 4'd9);
        bus.unit_done = 4'b0100;
        step();
        bus.unit_done = 4'b0000;
        check("t4_irq", {28'd0, bus.done_irq}, 32'h4);
        step();
        check("t4_irq_off", {28'd0, bus.done_irq}, 32'h0);
        wait_go("t4_go");
        cpu_read(JOB0 + 32'h8, rd); check("t4_job2", rd, 32'h8000_0009);

        // Two simultaneous dones: both forwarded, round-robin wraps to 0 then 1
        expect_go(4'b0001, 4'd10);
        expect_go(4'b0010, 4'd11);
        bus.unit_done = 4'b0011;
        step();
        bus.unit_done = 4'b0000;
        check("t5_irq", {28'd0, bus.done_irq}, 32'h3);
        cpu_read(STATUS, rd); check("t5_status_mid", rd, 32'h0000_00C3);
        wait_go("t5_gos");
        step();
        cpu_read(STATUS, rd); check("t5_status", rd, 32'h0000_00F1);

        // Reset while a dispatch is about to be registered
        cpu_write(SUBMIT, 32'd13);
        cpu_write(SUBMIT, 32'd14);
        cpu_read(STATUS, rd); check("t6_pre", rd, 32'h0000_00F3);
        bus.unit_done = 4'b0001;
        step();
        step();
        bus.unit_done = 4'b0000;
        rst = 1'b0;
        #1;
        check("t6_go", {28'd0, bus.unit_go}, 32'h0);
        check("t6_n", {28'd0, bus.unit_n}, 32'h0);
        check("t6_irq", {28'd0, bus.done_irq}, 32'h0);
        cpu_read(STATUS, rd); check("t6_status", rd, 32'h0000_0200);
        step();
        rst = 1'b1;
        bus.unit_done = 4'b0010;
        step();
        bus.unit_done = 4'b0000;
        check("t6_late_irq", {28'd0, bus.done_irq}, 32'h2);
        cpu_read(STATUS, rd); check("t6_status_late", rd, 32'h0000_0200);
        cpu_read(JOB0, rd);   check("t6_job0", rd, 32'h0);

        for (int i = 0; i < 6; i++) step();
        check("sb_empty", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
